object_move_ctrl: RTL and testbench



---
 rtl/obj_move_pkg.sv | 20 ++
 rtl/object_move_ctrl_if.sv | 29 ++
 rtl/axis_integrator.sv | 98 +++++++++
 rtl/object_move_ctrl.sv | 128 ++++++++++++
 tb/tb_object_move_ctrl.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/obj_move_pkg.sv
// Shared types and helpers for the sprite position controller.
package obj_move_pkg;

  typedef enum logic [1:0] {
    SPAWN  = 2'd0,
    ACTIVE = 2'd1,
    FROZEN = 2'd2
  } state_t;

  localparam int unsigned EDGE_W      = 4;
  localparam int unsigned EDGE_LEFT   = 3;
  localparam int unsigned EDGE_TOP    = 2;
  localparam int unsigned EDGE_RIGHT  = 1;
  localparam int unsigned EDGE_BOTTOM = 0;

  function automatic int to_fixed(input int px, input int unsigned frac);
    return px <<< frac;
  endfunction

endpackage

// File: rtl/object_move_ctrl_if.sv
// Direction/control inputs and sprite position outputs of the mover.
interface object_move_ctrl_if #(
  parameter int unsigned PIXEL_WIDTH = 11
);
  import obj_move_pkg::*;

  logic                          startOfFrame;
  logic                          enable;
  logic                          respawn;
  logic                          move_left;
  logic                          move_right;
  logic                          move_up;
  logic                          move_down;
  logic signed [PIXEL_WIDTH-1:0] topLeftX;
  logic signed [PIXEL_WIDTH-1:0] topLeftY;
  logic        [EDGE_W-1:0]      at_edge;
  logic                          spawning;

  modport master (
    output startOfFrame, enable, respawn, move_left, move_right, move_up, move_down,
    input  topLeftX, topLeftY, at_edge, spawning
  );

  modport slave (
    input  startOfFrame, enable, respawn, move_left, move_right, move_up, move_down,
    output topLeftX, topLeftY, at_edge, spawning
  );

endinterface

// File: rtl/axis_integrator.sv
// One axis of sprite motion: accelerate/friction, integrate, clamp to bounds.
module axis_integrator
  import obj_move_pkg::*;
#(
  parameter int unsigned POS_W     = 17,
  parameter int unsigned SPD_W     = 9,
  parameter int unsigned FRAC_BITS = 6,
  parameter int          INIT      = 300,
  parameter int          MIN       = 0,
  parameter int          MAX       = 600,
  parameter int unsigned MAX_SPEED = 128,
  parameter int unsigned ACCEL     = 32,
  parameter int unsigned FRICTION  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic                    i_update,
  input  logic                    i_dec,
  input  logic                    i_inc,
  output logic signed [POS_W-1:0] o_pos,
  output logic                    o_edge_lo,
  output logic                    o_edge_hi
);

  localparam int unsigned SW = SPD_W + 1;
  localparam int unsigned PW = POS_W + 1;
  localparam logic signed [SW-1:0] C_MAX_SPD = SW'(MAX_SPEED);
  localparam logic signed [SW-1:0] C_ACCEL   = SW'(ACCEL);
  localparam logic signed [SW-1:0] C_FRIC    = SW'(FRICTION);
  localparam logic signed [PW-1:0] C_INIT    = PW'(to_fixed(INIT, FRAC_BITS));
  localparam logic signed [PW-1:0] C_MIN     = PW'(to_fixed(MIN, FRAC_BITS));
  localparam logic signed [PW-1:0] C_MAX     = PW'(to_fixed(MAX, FRAC_BITS));

  logic signed [POS_W-1:0] r_pos;
  logic signed [SPD_W-1:0] r_speed;
  logic                    r_edge_lo;
  logic                    r_edge_hi;

  logic signed [SW-1:0] w_spd_ext;
  logic signed [SW-1:0] w_spd;
  logic signed [PW-1:0] w_sum;
  logic signed [PW-1:0] w_pos;
  logic                 w_lo;
  logic                 w_hi;

  // Speed is updated first; the new speed is what moves the position.
  always_comb begin
    w_spd_ext = SW'(r_speed);
    w_spd     = w_spd_ext;
    w_lo      = 1'b0;
    w_hi      = 1'b0;
    if (i_dec ^ i_inc) begin
      w_spd = i_inc ? (w_spd_ext + C_ACCEL) : (w_spd_ext - C_ACCEL);
      if (w_spd > C_MAX_SPD) begin
        w_spd = C_MAX_SPD;
      end else if (w_spd < -C_MAX_SPD) begin
        w_spd = -C_MAX_SPD;
      end
    end else if (w_spd_ext > C_FRIC) begin
      w_spd = w_spd_ext - C_FRIC;
    end else if (w_spd_ext < -C_FRIC) begin
      w_spd = w_spd_ext + C_FRIC;
    end else begin
      w_spd = '0;
    end
    w_sum = PW'(r_pos) + PW'(w_spd);
    w_pos = w_sum;
    if (w_sum < C_MIN) begin
      w_pos = C_MIN;
      w_spd = '0;
      w_lo  = 1'b1;
    end else if (w_sum > C_MAX) begin
      w_pos = C_MAX;
      w_spd = '0;
      w_hi  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_load) begin
      r_pos     <= POS_W'(C_INIT);
      r_speed   <= '0;
      r_edge_lo <= 1'b0;
      r_edge_hi <= 1'b0;
    end else if (i_update) begin
      r_pos     <= POS_W'(w_pos);
      r_speed   <= SPD_W'(w_spd);
      r_edge_lo <= w_lo;
      r_edge_hi <= w_hi;
    end
  end

  assign o_pos     = r_pos;
  assign o_edge_lo = r_edge_lo;
  assign o_edge_hi = r_edge_hi;

endmodule

// File: rtl/object_move_ctrl.sv
// Per-frame sprite mover: spawn/active/frozen sequencing around two axis integrators.
module object_move_ctrl
  import obj_move_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH  = 11,
  parameter int unsigned FRAC_BITS    = 6,
  parameter int          INITIAL_X    = 300,
  parameter int          INITIAL_Y    = 400,
  parameter int          MIN_X        = 0,
  parameter int          MAX_X        = 600,
  parameter int          MIN_Y        = 280,
  parameter int          MAX_Y        = 450,
  parameter int unsigned MAX_SPEED    = 128,
  parameter int unsigned ACCEL        = 32,
  parameter int unsigned FRICTION     = 32,
  parameter int unsigned SPAWN_FRAMES = 30
) (
  input  logic              clk,
  input  logic              reset,
  object_move_ctrl_if.slave bus
);

  localparam int unsigned POS_W = PIXEL_WIDTH + FRAC_BITS;
  localparam int unsigned SPD_W = $clog2(MAX_SPEED + 1) + 1;
  localparam int unsigned CNT_W = $clog2(SPAWN_FRAMES + 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_next_cnt;
  logic               r_spawning;
  logic               w_load;
  logic               w_update;
  logic signed [POS_W-1:0] w_pos_x;
  logic signed [POS_W-1:0] w_pos_y;
  logic               w_x_lo;
  logic               w_x_hi;
  logic               w_y_lo;
  logic               w_y_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= SPAWN;
      r_cnt      <= '0;
      r_spawning <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_cnt      <= w_next_cnt;
      r_spawning <= (w_next_state == SPAWN);
    end
  end

  // Respawn overrides everything, including a coincident frame update.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_load       = 1'b0;
    w_update     = 1'b0;
    if (bus.respawn) begin
      w_next_state = SPAWN;
      w_next_cnt   = '0;
      w_load       = 1'b1;
    end else begin
      case (r_state)
        SPAWN: begin
          w_load = 1'b1;
          if (bus.startOfFrame) begin
            if (r_cnt == CNT_W'(SPAWN_FRAMES - 1)) begin
              w_next_state = ACTIVE;
            end else begin
              w_next_cnt = r_cnt + CNT_W'(1);
            end
          end
        end
        ACTIVE: begin
          if (!bus.enable) begin
            w_next_state = FROZEN;
          end else if (bus.startOfFrame) begin
            w_update = 1'b1;
          end
        end
        FROZEN: begin
          if (bus.enable) begin
            w_next_state = ACTIVE;
          end
        end
        default: begin
          w_next_state = SPAWN;
          w_next_cnt   = '0;
          w_load       = 1'b1;
        end
      endcase
    end
  end

  axis_integrator #(
    .POS_W(POS_W), .SPD_W(SPD_W), .FRAC_BITS(FRAC_BITS),
    .INIT(INITIAL_X), .MIN(MIN_X), .MAX(MAX_X),
    .MAX_SPEED(MAX_SPEED), .ACCEL(ACCEL), .FRICTION(FRICTION)
  ) u_axis_x (
    .clk(clk), .reset(reset), .i_load(w_load), .i_update(w_update),
    .i_dec(bus.move_left), .i_inc(bus.move_right),
    .o_pos(w_pos_x), .o_edge_lo(w_x_lo), .o_edge_hi(w_x_hi)
  );

  axis_integrator #(
    .POS_W(POS_W), .SPD_W(SPD_W), .FRAC_BITS(FRAC_BITS),
    .INIT(INITIAL_Y), .MIN(MIN_Y), .MAX(MAX_Y),
    .MAX_SPEED(MAX_SPEED), .ACCEL(ACCEL), .FRICTION(FRICTION)
  ) u_axis_y (
    .clk(clk), .reset(reset), .i_load(w_load), .i_update(w_update),
    .i_dec(bus.move_up), .i_inc(bus.move_down),
    .o_pos(w_pos_y), .o_edge_lo(w_y_lo), .o_edge_hi(w_y_hi)
  );

  always_comb begin
    bus.at_edge              = '0;
    bus.at_edge[EDGE_LEFT]   = w_x_lo;
    bus.at_edge[EDGE_TOP]    = w_y_lo;
    bus.at_edge[EDGE_RIGHT]  = w_x_hi;
    bus.at_edge[EDGE_BOTTOM] = w_y_hi;
  end

  assign bus.topLeftX = PIXEL_WIDTH'(w_pos_x >>> FRAC_BITS);
  assign bus.topLeftY = PIXEL_WIDTH'(w_pos_y >>> FRAC_BITS);
  assign bus.spawning = r_spawning;

endmodule

// File: tb/tb_object_move_ctrl.sv
// Bench for object_move_ctrl: cycle model feeding a scoreboard plus scenario tasks.
module tb_object_move_ctrl;
  import obj_move_pkg::*;

  localparam int unsigned PW = 11;
  localparam int F = 6;
  localparam int SPAWN_X = 300, SPAWN_Y = 400;
  localparam int LO_X = 0, HI_X = 600, LO_Y = 280, HI_Y = 450;
  localparam int VMAX = 128, ACC = 32, FRIC = 32, NSPAWN = 30;

  typedef struct packed {
    logic signed [PW-1:0] x;
    logic signed [PW-1:0] y;
    logic [3:0]           edges;
    logic                 spw;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int m_st, m_cnt, m_px, m_py, m_vx, m_vy;
  logic [3:0] m_edge;

  object_move_ctrl_if #(.PIXEL_WIDTH(PW)) bus ();
  object_move_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic void axis_step(input int p, input int v, input bit neg, input bit pos,
                                    input int lo, input int hi,
                                    output int np, output int nv, output bit elo, output bit ehi);
    nv = v;
    if (neg != pos) begin
      nv = pos ? v + ACC : v - ACC;
      if (nv > VMAX) nv = VMAX;
      if (nv < -VMAX) nv = -VMAX;
    end else if (v > 0) nv = (v > FRIC) ? v - FRIC : 0;
    else if (v < 0) nv = (v < -FRIC) ? v + FRIC : 0;
    np = p + nv;
    elo = 1'b0;
    ehi = 1'b0;
    if (np < lo * 64) begin np = lo * 64; nv = 0; elo = 1'b1; end
    else if (np > hi * 64) begin np = hi * 64; nv = 0; ehi = 1'b1; end
  endfunction

  task automatic model_cycle(input bit rst, input bit sof, input bit en, input bit rsp,
                             input bit l, input bit r, input bit u, input bit d);
    int nx, ny, nvx, nvy;
    bit xl, xh, yl, yh;
    if (rst || rsp) begin
      m_st = 0; m_cnt = 0; m_px = SPAWN_X * 64; m_py = SPAWN_Y * 64;
      m_vx = 0; m_vy = 0; m_edge = 4'b0000;
    end else if (m_st == 0) begin
      if (sof) begin
        if (m_cnt == NSPAWN - 1) m_st = 1;
        else m_cnt++;
      end
    end else if (m_st == 1) begin
      if (!en) m_st = 2;
      else if (sof) begin
        axis_step(m_px, m_vx, l, r, LO_X, HI_X, nx, nvx, xl, xh);
        axis_step(m_py, m_vy, u, d, LO_Y, HI_Y, ny, nvy, yl, yh);
        m_px = nx; m_vx = nvx; m_py = ny; m_vy = nvy;
        m_edge = {xl, yl, xh, yh};
      end
    end else begin
      if (en) m_st = 1;
    end
  endtask

  // One clock of stimulus; the modelled post-edge outputs go to the scoreboard.
  task automatic step(input bit rst, input bit sof, input bit en, input bit rsp,
                      input bit l, input bit r, input bit u, input bit d);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus.startOfFrame = sof; bus.enable = en; bus.respawn = rsp;
    bus.move_left = l; bus.move_right = r; bus.move_up = u; bus.move_down = d;
    model_cycle(rst, sof, en, rsp, l, r, u, d);
    e.x = PW'(m_px >>> F);
    e.y = PW'(m_py >>> F);
    e.edges = m_edge;
    e.spw = (m_st == 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit l, input bit r, input bit u, input bit d);
    step(0, 1, 1, 0, l, r, u, d);
    step(0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      checks += 4;
      if (bus.topLeftX !== mon_e.x) begin
        failures++; $display("FAIL sb_x t=%0t got=%0d exp=%0d", $time, bus.topLeftX, mon_e.x);
      end
      if (bus.topLeftY !== mon_e.y) begin
        failures++; $display("FAIL sb_y t=%0t got=%0d exp=%0d", $time, bus.topLeftY, mon_e.y);
      end
      if (bus.at_edge !== mon_e.edges) begin
        failures++; $display("FAIL sb_edge t=%0t got=%b exp=%b", $time, bus.at_edge, mon_e.edges);
      end
      if (bus.spawning !== mon_e.spw) begin
        failures++; $display("FAIL sb_spawning t=%0t got=%b exp=%b", $time, bus.spawning, mon_e.spw);
      end
    end
  end

  task automatic test_reset();
    step(1, 0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (bus.spawning !== 1'b1 || bus.at_edge !== 4'b0000 || bus.topLeftX !== 11'sd300 || bus.topLeftY !== 11'sd400) begin
      failures++;
      $display("FAIL reset_state got sp=%b edge=%b x=%0d y=%0d exp sp=1 edge=0000 x=300 y=400",
               bus.spawning, bus.at_edge, bus.topLeftX, bus.topLeftY);
    end
  endtask

  task automatic test_spawn();
    repeat (NSPAWN - 1) frame(0, 1, 0, 1);
    checks++;
    if (bus.spawning !== 1'b1 || bus.topLeftX !== 11'sd300 || bus.topLeftY !== 11'sd400) begin
      failures++;
      $display("FAIL spawn_hold got sp=%b x=%0d y=%0d exp sp=1 x=300 y=400", bus.spawning, bus.topLeftX, bus.topLeftY);
    end
    frame(0, 1, 0, 1);
    checks++;
    if (bus.spawning !== 1'b0 || bus.topLeftX !== 11'sd300) begin
      failures++;
      $display("FAIL spawn_exit got sp=%b x=%0d exp sp=0 x=300", bus.spawning, bus.topLeftX);
    end
  endtask

  task automatic test_accel();
    int ex [5] = '{300, 301, 303, 305, 307};
    for (int i = 0; i < 5; i++) begin
      frame(0, 1, 0, 0);
      checks++;
      if (bus.topLeftX !== PW'(ex[i]) || bus.topLeftY !== 11'sd400) begin
        failures++;
        $display("FAIL accel_f%0d got x=%0d y=%0d exp x=%0d y=400", i, bus.topLeftX, bus.topLeftY, ex[i]);
      end
    end
  endtask

  task automatic test_friction();
    int ex [5] = '{308, 309, 310, 310, 310};
    for (int i = 0; i < 5; i++) begin
      frame(0, 0, 0, 0);
      checks++;
      if (bus.topLeftX !== PW'(ex[i])) begin
        failures++;
        $display("FAIL friction_f%0d got x=%0d exp x=%0d", i, bus.topLeftX, ex[i]);
      end
    end
  endtask

  task automatic test_clamp_bottom();
    bit hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      frame(0, 0, 0, 1);
      hit = bus.at_edge[EDGE_BOTTOM];
    end
    checks++;
    if (!hit || bus.topLeftY !== 11'sd450 || bus.at_edge !== 4'b0001) begin
      failures++;
      $display("FAIL clamp_bottom got hit=%b y=%0d edge=%b exp hit=1 y=450 edge=0001", hit, bus.topLeftY, bus.at_edge);
    end
    frame(0, 0, 1, 0);
    checks++;
    if (bus.at_edge !== 4'b0000 || bus.topLeftY !== 11'sd449) begin
      failures++;
      $display("FAIL clamp_release got edge=%b y=%0d exp edge=0000 y=449", bus.at_edge, bus.topLeftY);
    end
  endtask

  task automatic test_both_held();
    frame(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      frame(1, 1, 0, 0);
      checks++;
      if (bus.topLeftX !== 11'sd310 || bus.topLeftY !== 11'sd449) begin
        failures++;
        $display("FAIL both_held_f%0d got x=%0d y=%0d exp x=310 y=449", i, bus.topLeftX, bus.topLeftY);
      end
    end
  endtask

  task automatic test_freeze();
    frame(0, 1, 0, 0);
    frame(0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.topLeftX !== 11'sd311) begin
        failures++;
        $display("FAIL frozen_f%0d got x=%0d exp x=311", i, bus.topLeftX);
      end
    end
    step(0, 0, 1, 0, 0, 0, 0, 0);
    frame(0, 0, 0, 0);
    checks++;
    if (bus.topLeftX !== 11'sd312) begin
      failures++;
      $display("FAIL unfreeze_resume got x=%0d exp x=312", bus.topLeftX);
    end
  endtask

  task automatic test_respawn();
    frame(0, 1, 0, 0);
    checks++;
    if (bus.topLeftX !== 11'sd313) begin
      failures++;
      $display("FAIL pre_respawn got x=%0d exp x=313", bus.topLeftX);
    end
    step(0, 1, 1, 1, 0, 1, 0, 0);
    checks++;
    if (bus.topLeftX !== 11'sd300 || bus.topLeftY !== 11'sd400 || bus.spawning !== 1'b1 || bus.at_edge !== 4'b0000) begin
      failures++;
      $display("FAIL respawn got x=%0d y=%0d sp=%b edge=%b exp x=300 y=400 sp=1 edge=0000",
               bus.topLeftX, bus.topLeftY, bus.spawning, bus.at_edge);
    end
    step(0, 0, 1, 0, 0, 0, 0, 0);
    frame(0, 1, 0, 0);
    checks++;
    if (bus.spawning !== 1'b1 || bus.topLeftX !== 11'sd300) begin
      failures++;
      $display("FAIL respawn_hold got sp=%b x=%0d exp sp=1 x=300", bus.spawning, bus.topLeftX);
    end
  endtask

  task automatic test_clamp_top_left();
    bit hit = 1'b0;
    repeat (NSPAWN - 1) frame(0, 0, 0, 0);
    for (int i = 0; i < 200 && !hit; i++) begin
      frame(1, 0, 1, 0);
      hit = bus.at_edge[EDGE_LEFT];
    end
    checks++;
    if (!hit || bus.topLeftX !== 11'sd0 || bus.topLeftY !== 11'sd280 || bus.at_edge !== 4'b1100) begin
      failures++;
      $display("FAIL clamp_top_left got hit=%b x=%0d y=%0d edge=%b exp hit=1 x=0 y=280 edge=1100",
               hit, bus.topLeftX, bus.topLeftY, bus.at_edge);
    end
  endtask

  initial begin
    bus.startOfFrame = 1'b0; bus.enable = 1'b1; bus.respawn = 1'b0;
    bus.move_left = 1'b0; bus.move_right = 1'b0; bus.move_up = 1'b0; bus.move_down = 1'b0;
    test_reset();
    test_spawn();
    test_accel();
    test_friction();
    test_clamp_bottom();
    test_both_held();
    test_freeze();
    test_respawn();
    test_clamp_top_left();
    step(0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got pending=%0d exp pending=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
